imem_fetch_responder: RTL and testbench

//  Instruction-memory responder that answers fetch requests issued by the program counter stage.

---
 rtl/imem_fetch_responder.sv | 153 +++++++++++++++
 tb/tb_imem_fetch_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: word-addressed synchronous ROM behind a valid/ready
// request port, returning {instr, pc, err} in order through a one-stage read plus 2-entry queue.
module imem_fetch_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter              INIT_FILE   = "",
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_pc,
  output logic        rsp_err,
  input  logic        rsp_ready
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] rom [DEPTH_WORDS];

  // Read stage: one request whose ROM word is being fetched this cycle.
  logic        inflight_valid_reg, inflight_valid_next;
  logic [31:0] inflight_pc_reg, inflight_pc_next;
  logic        inflight_err_reg, inflight_err_next;
  logic [31:0] rom_data_reg;

  // Queue head doubles as the output register so that an empty queue keeps the last response.
  logic        rsp_valid_reg, rsp_valid_next;
  logic [31:0] rsp_instr_reg, rsp_instr_next;
  logic [31:0] rsp_pc_reg, rsp_pc_next;
  logic        rsp_err_reg, rsp_err_next;

  logic        q1_valid_reg, q1_valid_next;
  logic [31:0] q1_instr_reg, q1_instr_next;
  logic [31:0] q1_pc_reg, q1_pc_next;
  logic        q1_err_reg, q1_err_next;

  logic [29:0]   req_word;
  logic          req_err;
  logic [AW-1:0] rom_addr;
  logic [1:0]    occ;
  logic          pop;
  logic          accept;
  logic [31:0]   push_instr;

  assign req_word = req_pc[31:2];
  assign req_err  = (req_pc[1:0] != 2'b00) || ({2'b00, req_word} >= 32'(DEPTH_WORDS));
  // Error requests read word 0 so the ROM is never indexed out of range.
  assign rom_addr = req_err ? '0 : req_word[AW-1:0];

  assign occ       = {1'b0, inflight_valid_reg} + {1'b0, rsp_valid_reg} + {1'b0, q1_valid_reg};
  assign pop       = rsp_valid_reg && rsp_ready;
  assign req_ready = !reset && !flush && ((occ < 2'd2) || pop);
  assign accept    = req_valid && req_ready;

  assign push_instr = inflight_err_reg ? NOP_INSTR : rom_data_reg;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_instr = rsp_instr_reg;
  assign rsp_pc    = rsp_pc_reg;
  assign rsp_err   = rsp_err_reg;

  always_ff @(posedge clk) begin
    if (accept) begin
      rom_data_reg <= rom[rom_addr];
    end
  end

  always_comb begin
    inflight_valid_next = inflight_valid_reg;
    inflight_pc_next    = inflight_pc_reg;
    inflight_err_next   = inflight_err_reg;
    rsp_valid_next      = rsp_valid_reg;
    rsp_instr_next      = rsp_instr_reg;
    rsp_pc_next         = rsp_pc_reg;
    rsp_err_next        = rsp_err_reg;
    q1_valid_next       = q1_valid_reg;
    q1_instr_next       = q1_instr_reg;
    q1_pc_next          = q1_pc_reg;
    q1_err_next         = q1_err_reg;

    if (flush) begin
      inflight_valid_next = 1'b0;
      rsp_valid_next      = 1'b0;
      q1_valid_next       = 1'b0;
    end else begin
      inflight_valid_next = accept;
      if (accept) begin
        inflight_pc_next  = req_pc;
        inflight_err_next = req_err;
      end

      if (pop) begin
        if (q1_valid_reg) begin
          rsp_instr_next = q1_instr_reg;
          rsp_pc_next    = q1_pc_reg;
          rsp_err_next   = q1_err_reg;
          q1_valid_next  = 1'b0;
        end else begin
          rsp_valid_next = 1'b0;
        end
      end

      // occ<=2 guarantees the queue has room, so the read stage always drains.
      if (inflight_valid_reg) begin
        if (!rsp_valid_next) begin
          rsp_valid_next = 1'b1;
          rsp_instr_next = push_instr;
          rsp_pc_next    = inflight_pc_reg;
          rsp_err_next   = inflight_err_reg;
        end else begin
          q1_valid_next = 1'b1;
          q1_instr_next = push_instr;
          q1_pc_next    = inflight_pc_reg;
          q1_err_next   = inflight_err_reg;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_valid_reg <= 1'b0;
      inflight_pc_reg    <= '0;
      inflight_err_reg   <= 1'b0;
      rsp_valid_reg      <= 1'b0;
      rsp_instr_reg      <= '0;
      rsp_pc_reg         <= '0;
      rsp_err_reg        <= 1'b0;
      q1_valid_reg       <= 1'b0;
      q1_instr_reg       <= '0;
      q1_pc_reg          <= '0;
      q1_err_reg         <= 1'b0;
    end else begin
      inflight_valid_reg <= inflight_valid_next;
      inflight_pc_reg    <= inflight_pc_next;
      inflight_err_reg   <= inflight_err_next;
      rsp_valid_reg      <= rsp_valid_next;
      rsp_instr_reg      <= rsp_instr_next;
      rsp_pc_reg         <= rsp_pc_next;
      rsp_err_reg        <= rsp_err_next;
      q1_valid_reg       <= q1_valid_next;
      q1_instr_reg       <= q1_instr_next;
      q1_pc_reg          <= q1_pc_next;
      q1_err_reg         <= q1_err_next;
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: directed cycle vectors, reset/flush sequences, and a
// random valid/ready run checked against an in-order scoreboard with a latency model.
module tb_imem_fetch_responder;

  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, flush, req_valid, req_ready, rsp_valid, rsp_err, rsp_ready;
  logic [31:0] req_pc, rsp_instr, rsp_pc;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  imem_fetch_responder #(.DEPTH_WORDS(DEPTH), .INIT_FILE(""), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_pc(rsp_pc), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [31:0] romv(int i);
    return 32'hC0DE_0000 + i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        fl, v;
    logic [31:0] pc;
    logic        rdy;
    logic        e_rr, e_rv, chk_data;
    logic [31:0] e_instr, e_pc;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic fl, logic v, logic [31:0] pc, logic rdy, logic e_rr,
                              logic e_rv, logic cd, logic [31:0] ei, logic [31:0] ep, logic ee);
    vec_t x;
    x.fl = fl; x.v = v; x.pc = pc; x.rdy = rdy; x.e_rr = e_rr; x.e_rv = e_rv;
    x.chk_data = cd; x.e_instr = ei; x.e_pc = ep; x.e_err = ee;
    vecs.push_back(x);
  endfunction

  typedef struct {
    logic [31:0] instr, pc;
    logic        err;
    int          acc_edge;
  } sb_t;

  sb_t sb[$];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) dut.rom[i] = romv(i);
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("reset_req_ready", {31'b0, req_ready}, 0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("reset_rsp_instr", rsp_instr, 0);
    chk("reset_rsp_pc", rsp_pc, 0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 0);
    next_cycle();
    reset = 1'b0;

    // back-to-back fetch with rsp_ready=1
    add(0,1,0,1,  1,0,0,0,0,0);
    add(0,1,4,1,  1,0,0,0,0,0);
    add(0,1,8,1,  1,1,1,romv(0),0,0);
    add(0,1,12,1, 1,1,1,romv(1),4,0);
    add(0,0,0,1,  1,1,1,romv(2),8,0);
    add(0,0,0,1,  1,1,1,romv(3),12,0);
    add(0,0,0,1,  1,0,1,romv(3),12,0);
    // backpressure
    add(0,1,0,0,  1,0,1,romv(3),12,0);
    add(0,1,4,0,  1,0,0,0,0,0);
    add(0,1,8,0,  0,1,1,romv(0),0,0);
    add(0,1,8,0,  0,1,1,romv(0),0,0);
    add(0,1,8,1,  1,1,1,romv(0),0,0);
    add(0,0,0,1,  1,1,1,romv(1),4,0);
    add(0,0,0,1,  1,1,1,romv(2),8,0);
    add(0,0,0,1,  1,0,0,0,0,0);
    // misaligned, out of range, last valid word
    add(0,1,2,1,   1,0,0,0,0,0);
    add(0,1,256,1, 1,0,0,0,0,0);
    add(0,1,252,1, 1,1,1,NOP,2,1);
    add(0,0,0,1,   1,1,1,NOP,256,1);
    add(0,0,0,1,   1,1,1,romv(63),252,0);
    add(0,0,0,1,   1,0,1,romv(63),252,0);
    // flush with occ=2 and a request presented during the flush
    add(0,1,0,0,  1,0,0,0,0,0);
    add(0,1,4,0,  1,0,0,0,0,0);
    add(1,1,8,0,  0,1,1,romv(0),0,0);
    add(0,1,16,1, 1,0,1,romv(0),0,0);
    add(0,0,0,1,  1,0,0,0,0,0);
    add(0,0,0,1,  1,1,1,romv(4),16,0);
    add(0,0,0,1,  1,0,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      flush = vecs[i].fl; req_valid = vecs[i].v; req_pc = vecs[i].pc; rsp_ready = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_req_ready", i), {31'b0, req_ready}, {31'b0, vecs[i].e_rr});
      chk($sformatf("v%0d_rsp_valid", i), {31'b0, rsp_valid}, {31'b0, vecs[i].e_rv});
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d_rsp_instr", i), rsp_instr, vecs[i].e_instr);
        chk($sformatf("v%0d_rsp_pc", i), rsp_pc, vecs[i].e_pc);
        chk($sformatf("v%0d_rsp_err", i), {31'b0, rsp_err}, {31'b0, vecs[i].e_err});
      end
      next_cycle();
    end
    $display("directed vectors done: %0d applied", vecs.size());

    // reset mid-stream with occ=2
    flush = 0; rsp_ready = 0; req_valid = 1; req_pc = 0;
    next_cycle();
    req_pc = 4;
    next_cycle();
    reset = 1; req_pc = 8; rsp_ready = 1;
    @(negedge clk);
    chk("midrst_req_ready", {31'b0, req_ready}, 0);
    next_cycle();
    @(negedge clk);
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("midrst_req_ready2", {31'b0, req_ready}, 0);
    chk("midrst_rsp_instr", rsp_instr, 0);
    next_cycle();
    reset = 0; req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("postrst_rsp_valid%0d", i), {31'b0, rsp_valid}, 0);
      next_cycle();
    end
    $display("reset mid-stream sequence done");

    // random traffic against a scoreboard with a latency model
    begin
      int issued = 0;
      int popped = 0;
      int cyc = 0;
      while ((issued < 10000 || sb.size() != 0) && cyc < 80000) begin
        int r;
        logic exp_rv, exp_rr, do_pop;
        cyc++;
        flush = ($urandom_range(0, 499) == 0);
        req_valid = (issued < 10000) && ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 9);
        if (r == 0) req_pc = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        else if (r == 1) req_pc = 32'($urandom_range(DEPTH, 4000) * 4);
        else req_pc = 32'($urandom_range(0, DEPTH - 1) * 4);
        rsp_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        exp_rv = (sb.size() != 0) && (edge_cnt >= sb[0].acc_edge + 1);
        do_pop = exp_rv && rsp_ready;
        exp_rr = !flush && (sb.size() < 2 || do_pop);
        chk("rnd_rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_rv});
        chk("rnd_req_ready", {31'b0, req_ready}, {31'b0, exp_rr});
        if (do_pop) begin
          chk("rnd_rsp_instr", rsp_instr, sb[0].instr);
          chk("rnd_rsp_pc", rsp_pc, sb[0].pc);
          chk("rnd_rsp_err", {31'b0, rsp_err}, {31'b0, sb[0].err});
          void'(sb.pop_front());
          popped++;
        end
        if (flush) begin
          sb.delete();
        end else if (req_valid && exp_rr) begin
          sb_t e;
          e.pc = req_pc;
          e.err = (req_pc[1:0] != 0) || (req_pc[31:2] >= DEPTH);
          e.instr = e.err ? NOP : romv(int'(req_pc[31:2]));
          e.acc_edge = edge_cnt + 1;
          sb.push_back(e);
          issued++;
        end
        next_cycle();
      end
      chk("rnd_drained", 32'(sb.size()), 0);
      chk("rnd_issued", 32'(issued), 10000);
      $display("random run: %0d issued, %0d popped, %0d cycles", issued, popped, cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
